// File: rtl/demux_1_4_reg.sv
// rtl/demux_1_4_reg.sv - registered 1-to-4 demultiplexer with per-channel ready/valid holding registers
//
// Purpose:
//   Routes one N-bit input word per cycle to one of four output channels
//   (A..D) selected by i_in_sel. Each channel is a single-entry holding
//   register with an EMPTY/FULL state and ready/valid handshake on both
//   sides. A full channel that is draining in the same cycle can accept a
//   new word with no bubble.
//
// Configuration macro:
//   DEMUX_1_4_XFER_CNT_EN - when defined, o_xfer_cnt carries four saturating
//                           8-bit output-transfer counters; when undefined
//                           o_xfer_cnt is tied to zero and no counters exist.
//
// Ports:
//   i_clk          clock, all state updates on the rising edge
//   i_rst_n        synchronous active-low reset
//   i_in_data      [N-1:0] word to route
//   i_in_sel       [1:0]   destination: 0=A, 1=B, 2=C, 3=D
//   i_in_valid     input word valid this cycle
//   o_in_ready     block accepts the word this cycle (combinational)
//   o_out_a..d     [N-1:0] channel holding-register contents
//   o_out_valid    [3:0]   per-channel valid, bit0=A .. bit3=D
//   i_out_ready    [3:0]   per-channel consumer ready, same order
//   o_xfer_cnt     [31:0]  packed counters, [7:0]=A .. [31:24]=D

module demux_1_4_reg #(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_in_data,
  input  logic [1:0]   i_in_sel,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  output logic [N-1:0] o_out_a,
  output logic [N-1:0] o_out_b,
  output logic [N-1:0] o_out_c,
  output logic [N-1:0] o_out_d,
  output logic [3:0]   o_out_valid,
  input  logic [3:0]   i_out_ready,
  output logic [31:0]  o_xfer_cnt
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic [3:0]   r_state;
  logic [N-1:0] r_data [4];

  logic         w_in_ready;
  logic         w_accept;
  logic [3:0]   w_load;
  logic [3:0]   w_xfer;

  // Only the selected channel decides readiness; a full channel may take a
  // new word when its consumer is draining it in the same cycle.
  assign w_in_ready = (r_state[i_in_sel] == ST_EMPTY) | i_out_ready[i_in_sel];
  assign w_accept   = i_in_valid & w_in_ready;
  assign w_xfer     = r_state & i_out_ready;

  always_comb begin
    w_load = 4'b0000;
    if (w_accept) begin
      w_load[i_in_sel] = 1'b1;
    end
  end

  // Load takes priority over drain so a simultaneous drain+load stays FULL
  // with the new word.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= {4{ST_EMPTY}};
      for (int k = 0; k < 4; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_load[k]) begin
          r_state[k] <= ST_FULL;
          r_data[k]  <= i_in_data;
        end else if (w_xfer[k]) begin
          r_state[k] <= ST_EMPTY;
        end
      end
    end
  end

`ifdef DEMUX_1_4_XFER_CNT_EN
  logic [7:0] r_cnt [4];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 4; k++) begin
        r_cnt[k] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_xfer[k] && (r_cnt[k] != 8'hFF)) begin
          r_cnt[k] <= r_cnt[k] + 8'h01;
        end
      end
    end
  end

  assign o_xfer_cnt = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
`else
  assign o_xfer_cnt = 32'h0000_0000;
`endif

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_state;
  assign o_out_a     = r_data[0];
  assign o_out_b     = r_data[1];
  assign o_out_c     = r_data[2];
  assign o_out_d     = r_data[3];

endmodule
